// File: rtl/digit_store_pkg.sv
// digit_store_pkg: shared widths and digit type for the keypad digit buffer.
package digit_store_pkg;
    localparam int DIGIT_W = 4;
    localparam int DEFAULT_NUM_DIGITS = 4;
    typedef logic [DIGIT_W-1:0] digit_t;
endpackage

// File: rtl/digit_store_if.sv
// digit_store_if: keypad-side strobe/digit inputs and display-side buffer outputs.
interface digit_store_if import digit_store_pkg::*; #(
    parameter int NUM_DIGITS = DEFAULT_NUM_DIGITS
);
    digit_t                          digit;
    logic                            valid;
    logic                            clear;
    logic [DIGIT_W*NUM_DIGITS-1:0]   out;
    logic [NUM_DIGITS-1:0]           digitsToDisplay;
    logic                            storageFull;

    modport master (output digit, valid, clear, input out, digitsToDisplay, storageFull);
    modport slave  (input digit, valid, clear, output out, digitsToDisplay, storageFull);
endinterface

// File: rtl/digit_store_rise_detect.sv
// rise_detect: registers a level strobe and emits a one-cycle pulse on its rising edge.
module rise_detect (
    input  logic clk,
    input  logic reset,
    input  logic in,
    output logic pulse
);
    logic in_q;

    always_ff @(posedge clk or negedge reset)
        if (!reset) in_q <= 1'b0;
        else        in_q <= in;

    assign pulse = in & ~in_q;
endmodule

// File: rtl/digit_store.sv
// digit_store: calculator-style hex digit entry buffer with occupancy mask and full flag.
// DIGITSTORE_OVERWRITE_EN: accepts while full shift out the oldest digit instead of being dropped.
module digit_store import digit_store_pkg::*; #(
    parameter int NUM_DIGITS = DEFAULT_NUM_DIGITS
) (
    input logic          clk,
    input logic          reset,
    digit_store_if.slave bus
);
    localparam int W  = DIGIT_W * NUM_DIGITS;
    localparam int CW = $clog2(NUM_DIGITS + 1);
`ifdef DIGITSTORE_OVERWRITE_EN
    localparam bit OVR = 1'b1;
`else
    localparam bit OVR = 1'b0;
`endif

    logic          acc;
    logic          full;
    logic [W-1:0]  out_q;
    logic [CW-1:0] cnt;

    rise_detect u_rise (
        .clk   (clk),
        .reset (reset),
        .in    (bus.valid),
        .pulse (acc)
    );

    assign full = cnt == CW'(NUM_DIGITS);

    // clear wins over a coincident accept; count saturates at NUM_DIGITS
    always_ff @(posedge clk or negedge reset)
        if (!reset) begin
            out_q <= '0;
            cnt   <= '0;
        end else if (bus.clear) begin
            out_q <= '0;
            cnt   <= '0;
        end else if (acc && (!full || OVR)) begin
            out_q <= {out_q[W-DIGIT_W-1:0], bus.digit};
            cnt   <= full ? cnt : cnt + CW'(1);
        end

    for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_mask
        assign bus.digitsToDisplay[g] = cnt > CW'(g);
    end

    assign bus.out         = out_q;
    assign bus.storageFull = full;
endmodule

// File: tb/tb_digit_store.sv
// tb_digit_store: directed scoreboard bench for digit_store.
module tb_digit_store;
    import digit_store_pkg::*;
    localparam int N = 4;
`ifdef DIGITSTORE_OVERWRITE_EN
    localparam bit OVR = 1'b1;
`else
    localparam bit OVR = 1'b0;
`endif

    typedef struct packed {
        logic [15:0] out;
        logic [3:0]  mask;
        logic        full;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b0;
    int   total = 0;
    int   fails = 0;
    exp_t sb[$];

    logic [15:0] m_out = '0;
    int          m_cnt = 0;
    logic        m_vq = 1'b0;

    digit_store_if #(.NUM_DIGITS(N)) bus ();
    digit_store #(.NUM_DIGITS(N)) dut (.clk(clk), .reset(reset), .bus(bus));

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        total++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic check_outs(input string tag, input exp_t e);
        chk({tag, ".out"}, bus.out, e.out);
        chk({tag, ".mask"}, 16'(bus.digitsToDisplay), 16'(e.mask));
        chk({tag, ".full"}, 16'(bus.storageFull), 16'(e.full));
    endtask

    task automatic model_reset();
        m_out = '0;
        m_cnt = 0;
        m_vq  = 1'b0;
        sb.delete();
    endtask

    // drive one cycle, predict its result, then compare after the edge
    task automatic cyc(input string tag, input logic v, input digit_t d, input logic c);
        exp_t e;
        bus.valid = v;
        bus.digit = d;
        bus.clear = c;
        if (c) begin
            m_out = '0;
            m_cnt = 0;
        end else if (v && !m_vq && (m_cnt < N || OVR)) begin
            m_out = {m_out[11:0], d};
            if (m_cnt < N) m_cnt++;
        end
        m_vq   = v;
        e.out  = m_out;
        e.mask = 4'((1 << m_cnt) - 1);
        e.full = m_cnt == N;
        sb.push_back(e);
        @(posedge clk);
        #1;
        if (sb.size() == 0) chk({tag, ".sb_empty"}, 16'd1, 16'd0);
        else check_outs(tag, sb.pop_front());
    endtask

    initial begin
        bus.valid = 1'b0;
        bus.digit = '0;
        bus.clear = 1'b0;
        #12;
        check_outs("reset", '{out: 16'h0, mask: 4'h0, full: 1'b0});
        reset = 1'b1;
        cyc("first", 1'b1, 4'h0, 1'b0);
        chk("first.mask_const", 16'(bus.digitsToDisplay), 16'h0001);
        for (int i = 0; i < 3; i++) begin
            cyc("gapA", 1'b0, 4'hA, 1'b0);
            cyc("pulseA", 1'b1, 4'hA, 1'b0);
        end
        chk("full.out_const", bus.out, 16'h0AAA);
        chk("full.flag_const", 16'(bus.storageFull), 16'h0001);
        cyc("gap5", 1'b0, 4'hA, 1'b0);
        cyc("fifth", 1'b1, 4'hA, 1'b0);
        chk("fifth.out_const", bus.out, OVR ? 16'hAAAA : 16'h0AAA);
        chk("fifth.mask_const", 16'(bus.digitsToDisplay), 16'h000F);
        cyc("clr", 1'b0, 4'h0, 1'b1);
        for (int i = 0; i < 5; i++) cyc("hold3", 1'b1, 4'h3, 1'b0);
        chk("hold.out_const", bus.out, 16'h0003);
        chk("hold.mask_const", 16'(bus.digitsToDisplay), 16'h0001);
        cyc("clr_held", 1'b1, 4'h0, 1'b1);
        cyc("gap", 1'b0, 4'h0, 1'b0);
        cyc("d1", 1'b1, 4'h1, 1'b0);
        cyc("gap", 1'b0, 4'h1, 1'b0);
        cyc("d2", 1'b1, 4'h2, 1'b0);
        cyc("gap", 1'b0, 4'h2, 1'b0);
        chk("pre_clr.out_const", bus.out, 16'h0012);
        cyc("clr_acc", 1'b1, 4'h7, 1'b1);
        chk("clr_acc.out_const", bus.out, 16'h0000);
        chk("clr_acc.mask_const", 16'(bus.digitsToDisplay), 16'h0000);
        cyc("after_clr_hold", 1'b1, 4'h7, 1'b0);
        cyc("gap", 1'b0, 4'h7, 1'b0);
        for (int i = 0; i < 6; i++) begin
            cyc("rnd", 1'b1, 4'($urandom_range(15)), 1'b0);
            cyc("gap", 1'b0, 4'h0, 1'b0);
        end
        #3;
        reset = 1'b0;
        #1;
        check_outs("async_rst", '{out: 16'h0, mask: 4'h0, full: 1'b0});
        model_reset();
        #1;
        reset = 1'b1;
        cyc("post_rst", 1'b1, 4'h5, 1'b0);
        cyc("gap", 1'b0, 4'h0, 1'b0);
        cyc("post_rst2", 1'b1, 4'h9, 1'b0);
        chk("post_rst.out_const", bus.out, 16'h0059);
        $display("%0d/%0d checks passed", total - fails, total);
        $finish;
    end
endmodule
